// File: rtl/fetch.sv
// fetch: RV32 instruction fetch stage with a credit-limited prefetch FIFO
module fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_flush,
    input  logic [31:0] ex_if__jump_target,
    input  logic        data_hazard,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id__ins,
    output logic [31:0] if_id__pc,
    output logic        if_id__data_hazard
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BUBBLE_PC = 32'hffff_ffff;

    logic [31:0] fetch_pc, resp_pc;
    logic [CW-1:0] outstanding, drop_cnt, fifo_count, drop_next;
    logic [CW:0] drop_sum;
    logic [PW-1:0] head, tail;
    logic [31:0] fifo_ins [FIFO_DEPTH];
    logic [31:0] fifo_pc [FIFO_DEPTH];
    logic rv, keep, accept, advance, pop, bypass, push;

    // Issue gating by credit, and classification of each response word
    always_comb begin
        imem_req  = rst_n && !pipe_flush && (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH);
        imem_addr = fetch_pc;
        accept    = imem_req && imem_ready;
        rv        = imem_rvalid && (outstanding != '0);
        keep      = rv && (drop_cnt == '0) && !pipe_flush;
        advance   = !pipe_flush && !data_hazard;
        pop       = advance && (fifo_count != '0);
        bypass    = advance && (fifo_count == '0) && keep;
        push      = keep && !bypass;
        drop_sum  = {1'b0, drop_cnt} + {1'b0, outstanding} - (CW + 1)'(rv);
        drop_next = (drop_sum > DEPTH) ? DEPTH[CW-1:0] : drop_sum[CW-1:0];
    end

    // PCs, credit counters, FIFO pointers and the if_id__ output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc           <= RESET_PC;
            resp_pc            <= RESET_PC;
            outstanding        <= '0;
            drop_cnt           <= '0;
            fifo_count         <= '0;
            head               <= '0;
            tail               <= '0;
            if_id__ins         <= NOP;
            if_id__pc          <= BUBBLE_PC;
            if_id__data_hazard <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rv);
            if (pipe_flush) begin
                fetch_pc           <= ex_if__jump_target;
                resp_pc            <= ex_if__jump_target;
                drop_cnt           <= drop_next;
                fifo_count         <= '0;
                head               <= '0;
                tail               <= '0;
                if_id__ins         <= NOP;
                if_id__pc          <= BUBBLE_PC;
                if_id__data_hazard <= 1'b0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (keep) resp_pc <= resp_pc + 32'd4;
                if (rv && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                if (push) tail <= (tail == LAST) ? '0 : tail + PW'(1);
                if (pop) head <= (head == LAST) ? '0 : head + PW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (data_hazard) begin
                    if_id__data_hazard <= 1'b1;
                end else begin
                    if_id__data_hazard <= 1'b0;
                    if_id__ins <= pop ? fifo_ins[head] : bypass ? imem_rdata : NOP;
                    if_id__pc  <= pop ? fifo_pc[head] : bypass ? resp_pc : BUBBLE_PC;
                end
            end
        end
    end

    // FIFO storage; entries are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ins[tail] <= imem_rdata;
            fifo_pc[tail]  <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for fetch with a variable-latency memory model and scoreboard
module tb_fetch;
    localparam logic [31:0] BUB = 32'hffff_ffff;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, pipe_flush, data_hazard, imem_ready, imem_rvalid;
    logic [31:0] ex_if__jump_target, imem_rdata;
    logic        imem_req, if_id__data_hazard;
    logic [31:0] imem_addr, if_id__ins, if_id__pc;

    fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pipe_flush(pipe_flush),
        .ex_if__jump_target(ex_if__jump_target),
        .data_hazard(data_hazard),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_id__ins(if_id__ins),
        .if_id__pc(if_id__pc),
        .if_id__data_hazard(if_id__data_hazard)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

    mreq_t mq[$];
    exp_t  sb[$];
    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 1;
    int tb_out = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h0000_000a + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: memory accepts/responds, expected words enter and leave the scoreboard
    task automatic cycle();
        logic acc, fl, hz, rv;
        logic [31:0] a;
        exp_t e;
        #1;
        acc = imem_req && imem_ready;
        a   = imem_addr;
        fl  = pipe_flush;
        hz  = data_hazard;
        rv  = imem_rvalid;
        @(posedge clk);
        #1;
        cyc++;
        tb_out = tb_out + int'(acc) - int'(rv);
        if (fl) sb.delete();
        if (acc) begin
            mq.push_back('{a, cyc + lat - 1});
            sb.push_back('{a, word_of(a)});
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(mq[0].addr);
            mq.delete(0);
        end
        chk("protocol", 32'(!imem_rvalid || tb_out > 0), 32'd1);
        chk("credit", 32'(tb_out <= 2), 32'd1);
        if (fl) begin
            chk("flush_pc", if_id__pc, BUB);
            chk("flush_ins", if_id__ins, NOP);
        end else if (!hz && if_id__pc !== BUB) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", if_id__pc, BUB);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", if_id__pc, e.pc);
                chk("sb_ins", if_id__ins, e.ins);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pipe_flush = 1'b0;
        data_hazard = 1'b0;
        imem_ready = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        ex_if__jump_target = 32'h0;
        mq.delete();
        sb.delete();
        tb_out = 0;
        @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", if_id__pc, BUB);
        chk("rst_ins", if_id__ins, NOP);
        chk("rst_hz", 32'(if_id__data_hazard), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'h0);
    endtask

    task automatic wait_pc(input logic [31:0] pc, input string tag);
        int i = 0;
        while (if_id__pc !== pc && i < 40) begin
            cycle();
            i++;
        end
        chk(tag, if_id__pc, pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset release and 1-cycle memory
        lat = 1;
        do_reset();
        cycle(); chk("t1_e1_pc", if_id__pc, BUB);
        cycle(); chk("t1_pc0", if_id__pc, 32'h0); chk("t1_ins0", if_id__ins, 32'ha);
        cycle(); chk("t1_pc4", if_id__pc, 32'h4); chk("t1_ins4", if_id__ins, 32'hb);
        cycle(); chk("t1_pc8", if_id__pc, 32'h8); chk("t1_ins8", if_id__ins, 32'hc);

        // memory not ready for 3 cycles
        do_reset();
        imem_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("t2_addr", imem_addr, 32'h0);
            chk("t2_pc", if_id__pc, BUB);
        end
        imem_ready = 1'b1;
        cycle(); chk("t2_first", if_id__pc, BUB);
        cycle(); chk("t2_pc0", if_id__pc, 32'h0);
        cycle(); chk("t2_pc4", if_id__pc, 32'h4);

        // load-use hazard holds the output while the FIFO fills
        cycle(); chk("t3_pc8", if_id__pc, 32'h8);
        data_hazard = 1'b1;
        cycle(); chk("t3_hold1", if_id__pc, 32'h8); chk("t3_hz1", 32'(if_id__data_hazard), 32'd1);
        cycle(); chk("t3_hold2", if_id__pc, 32'h8); chk("t3_hz2", 32'(if_id__data_hazard), 32'd1);
        chk("t3_req_off", 32'(imem_req), 32'd0);
        data_hazard = 1'b0;
        cycle(); chk("t3_pcC", if_id__pc, 32'hc); chk("t3_hz_clr", 32'(if_id__data_hazard), 32'd0);
        cycle(); chk("t3_pc10", if_id__pc, 32'h10);

        // flush with two requests in flight on a 3-cycle memory
        lat = 3;
        do_reset();
        cycle();
        cycle();
        pipe_flush = 1'b1;
        ex_if__jump_target = 32'h100;
        cycle();
        pipe_flush = 1'b0;
        chk("t4_bub", if_id__pc, BUB);
        chk("t4_addr", imem_addr, 32'h100);
        wait_pc(32'h100, "t4_pc100");
        chk("t4_ins100", if_id__ins, word_of(32'h100));
        cycle(); chk("t4_pc104", if_id__pc, 32'h104);

        // flush and hazard together, target just below the wrap point
        lat = 1;
        do_reset();
        wait_pc(32'h8, "t5_pc8");
        pipe_flush = 1'b1;
        data_hazard = 1'b1;
        ex_if__jump_target = 32'hffff_fff8;
        cycle();
        pipe_flush = 1'b0;
        data_hazard = 1'b0;
        chk("t5_bub_pc", if_id__pc, BUB);
        chk("t5_bub_ins", if_id__ins, NOP);
        chk("t5_bub_hz", 32'(if_id__data_hazard), 32'd0);
        wait_pc(32'hffff_fff8, "t5_pcF8");
        cycle(); chk("t5_pcFC", if_id__pc, 32'hffff_fffc);
        cycle(); chk("t5_wrap", if_id__pc, 32'h0);
        cycle(); chk("t5_pc4", if_id__pc, 32'h4);

        // asynchronous reset mid-stream
        do_reset();
        wait_pc(32'h40, "t6_pc40");
        rst_n = 1'b0;
        #1;
        chk("t6_pc", if_id__pc, BUB);
        chk("t6_ins", if_id__ins, NOP);
        chk("t6_req", 32'(imem_req), 32'd0);
        do_reset();
        cycle(); chk("t6_e1", if_id__pc, BUB);
        cycle(); chk("t6_pc0", if_id__pc, 32'h0); chk("t6_ins0", if_id__ins, 32'ha);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
